// File: rtl/mod_reduce_seq_if.sv
// mod_reduce_seq_if: handshake bundle between the multiplier, the reducer and its consumer
//   in_valid  master->slave  product/modulus valid (level; multiplier done)
//   in_ready  slave->master  reducer can accept a new product
//   ab        master->slave  2*width-bit product to reduce
//   p         master->slave  width-bit modulus, sampled with ab
//   out_valid slave->master  r/err valid, held until out_ready
//   out_ready master->slave  consumer accepts r
//   r         slave->master  ab mod p
//   err       slave->master  modulus was zero, qualified by out_valid
interface mod_reduce_seq_if #(
    parameter int width = 128
);
    logic               in_valid;
    logic               in_ready;
    logic [2*width-1:0] ab;
    logic [width-1:0]   p;
    logic               out_valid;
    logic               out_ready;
    logic [width-1:0]   r;
    logic               err;
    modport master (
        output in_valid, ab, p, out_ready,
        input  in_ready, out_valid, r, err
    );
    modport slave (
        input  in_valid, ab, p, out_ready,
        output in_ready, out_valid, r, err
    );
endinterface

// File: rtl/mod_reduce_seq.sv
// mod_reduce_seq: sequential restoring shift-subtract reducer, r = ab mod p, one product bit per cycle
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    mod_reduce_seq_if.slave: in_valid/in_ready/ab/p in, out_valid/out_ready/r/err out
// Optional feature macro: MOD_REDUCE_BYPASS_EN (already-reduced products skip the RUN phase)
module mod_reduce_seq #(
    parameter int width = 128
) (
    input  logic             clk,
    input  logic             reset,
    mod_reduce_seq_if.slave  bus
);
    localparam int CW = $clog2(2 * width);
    localparam logic [CW-1:0] LAST = CW'(2 * width - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state_q;
    logic [2*width-1:0] sh_q;
    logic [width-1:0]   preg_q;
    logic [width-1:0]   rem_q;
    logic [CW-1:0]      count_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [width-1:0]   r_q;
    logic               err_q;
    logic [width:0]     t_d;
    logic [width:0]     pext_d;
    logic [width-1:0]   rem_d;
    // rem < preg holds, so t < 2*preg fits width+1 bits and the restored value fits width bits
    assign t_d    = {rem_q, sh_q[2*width-1]};
    assign pext_d = {1'b0, preg_q};
    assign rem_d  = (t_d >= pext_d) ? width'(t_d - pext_d) : t_d[width-1:0];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            preg_q      <= '0;
            rem_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            r_q         <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    sh_q       <= bus.ab;
                    preg_q     <= bus.p;
                    rem_q      <= '0;
                    count_q    <= '0;
                    in_ready_q <= 1'b0;
                    err_q      <= 1'b0;
                    if (bus.p == '0) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        err_q       <= 1'b1;
                        r_q         <= '0;
                    end
`ifdef MOD_REDUCE_BYPASS_EN
                    else if (bus.ab[2*width-1:width] == '0 && bus.ab[width-1:0] < bus.p) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        r_q         <= bus.ab[width-1:0];
                    end
`endif
                    else state_q <= RUN;
                end
                RUN: begin
                    sh_q    <= sh_q << 1;
                    rem_q   <= rem_d;
                    count_q <= count_q + CW'(1);
                    if (count_q == LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        r_q         <= rem_d;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.r         = r_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mod_reduce_seq.sv
// tb_mod_reduce_seq: table-driven and scoreboard checks of mod_reduce_seq at width 8 and 128
module tb_mod_reduce_seq;
    localparam int W = 8;
    localparam int WB = 128;
    localparam int NR = 100;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;
    mod_reduce_seq_if #(.width(W))  b8();
    mod_reduce_seq_if #(.width(WB)) b128();
    mod_reduce_seq #(.width(W))  dut8   (.clk(clk), .reset(reset), .bus(b8));
    mod_reduce_seq #(.width(WB)) dut128 (.clk(clk), .reset(reset), .bus(b128));
    typedef struct {
        logic [15:0] ab;
        logic [7:0]  p;
        logic [7:0]  r;
        logic        err;
    } vec_t;
    typedef struct {
        logic [7:0] r;
        logic       err;
        int         lat;
    } exp8_t;
    vec_t         vt[11];
    exp8_t        q8[$];
    logic [127:0] q128[$];
    int tests = 0;
    int fails = 0;
    int got = 0;
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic int lat_of(input logic [15:0] ab, input logic [7:0] p);
`ifdef MOD_REDUCE_BYPASS_EN
        if (p != 0 && ab[15:8] == 0 && ab[7:0] < p) return 0;
`endif
        return (p == 0) ? 0 : 2 * W;
    endfunction
    task automatic retire8();
        @(negedge clk);
        b8.out_ready = 1'b1;
        @(posedge clk);
        #1 b8.out_ready = 1'b0;
    endtask
    // n counts clock edges after the accepting edge until out_valid is seen
    task automatic issue8(input logic [15:0] ab, input logic [7:0] p, input logic [7:0] r,
                          input logic e, input bit ret);
        int n;
        exp8_t x;
        @(negedge clk);
        n = 0;
        while (!b8.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_before_accept", 128'(b8.in_ready), 128'(1));
        b8.ab = ab;
        b8.p = p;
        b8.in_valid = 1'b1;
        q8.push_back('{r, e, lat_of(ab, p)});
        @(posedge clk);
        #1 b8.in_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (!b8.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        x = q8.pop_front();
        if (!b8.out_valid) begin
            tests++;
            fails++;
            $display("FAIL out_valid_timeout: got 0 expected 1 (ab=%0h p=%0h)", ab, p);
            return;
        end
        chk($sformatf("r ab=%0h p=%0h", ab, p), 128'(b8.r), 128'(x.r));
        chk($sformatf("err ab=%0h p=%0h", ab, p), 128'(b8.err), 128'(x.err));
        chk($sformatf("latency ab=%0h p=%0h", ab, p), 128'(n), 128'(x.lat));
        if (ret) retire8();
    endtask
    initial begin
        vt[0]  = '{16'hFFFF, 8'd251, 8'd24, 1'b0};
        vt[1]  = '{16'd63001, 8'd251, 8'd0, 1'b0};
        vt[2]  = '{16'd0, 8'd7, 8'd0, 1'b0};
        vt[3]  = '{16'd250, 8'd251, 8'd250, 1'b0};
        vt[4]  = '{16'd1234, 8'd0, 8'd0, 1'b1};
        vt[5]  = '{16'd1000, 8'd13, 8'd12, 1'b0};
        vt[6]  = '{16'd255, 8'd255, 8'd0, 1'b0};
        vt[7]  = '{16'hFF00, 8'd1, 8'd0, 1'b0};
        vt[8]  = '{16'h0100, 8'd200, 8'd56, 1'b0};
        vt[9]  = '{16'd5, 8'd255, 8'd5, 1'b0};
        vt[10] = '{16'hABCD, 8'd97, 8'd40, 1'b0};
        reset = 1'b1;
        b8.in_valid = 1'b0;
        b8.ab = '0;
        b8.p = '0;
        b8.out_ready = 1'b0;
        b128.in_valid = 1'b0;
        b128.ab = '0;
        b128.p = '0;
        b128.out_ready = 1'b0;
        #12;
        chk("reset in_ready", 128'(b8.in_ready), 128'(1));
        chk("reset out_valid", 128'(b8.out_valid), 128'(0));
        chk("reset r", 128'(b8.r), 128'(0));
        chk("reset err", 128'(b8.err), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 11; i++) issue8(vt[i].ab, vt[i].p, vt[i].r, vt[i].err, 1'b1);
        // backpressure: result held, in_valid pulses ignored while DONE
        issue8(16'hFFFF, 8'd251, 8'd24, 1'b0, 1'b0);
        b8.ab = 16'd5;
        b8.p = 8'd7;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            b8.in_valid = ~b8.in_valid;
            chk("hold out_valid", 128'(b8.out_valid), 128'(1));
            chk("hold r", 128'(b8.r), 128'(24));
            chk("hold in_ready", 128'(b8.in_ready), 128'(0));
        end
        @(negedge clk);
        b8.in_valid = 1'b0;
        retire8();
        chk("retire out_valid", 128'(b8.out_valid), 128'(0));
        chk("retire in_ready", 128'(b8.in_ready), 128'(1));
        chk("retire r kept", 128'(b8.r), 128'(24));
        issue8(16'd250, 8'd251, 8'd250, 1'b0, 1'b1);
        // reset in the middle of RUN aborts immediately
        @(negedge clk);
        b8.ab = 16'd1000;
        b8.p = 8'd13;
        b8.in_valid = 1'b1;
        @(posedge clk);
        #1 b8.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort in_ready", 128'(b8.in_ready), 128'(1));
        chk("abort out_valid", 128'(b8.out_valid), 128'(0));
        chk("abort r", 128'(b8.r), 128'(0));
        chk("abort err", 128'(b8.err), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        issue8(16'd1000, 8'd13, 8'd12, 1'b0, 1'b1);
        // width 128 back-to-back random products
        b128.out_ready = 1'b1;
        fork
            begin
                logic [255:0] abv;
                logic [127:0] pv;
                int n;
                for (int i = 0; i < NR; i++) begin
                    abv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                    pv = (i % 4 == 0) ? 128'($urandom) : {$urandom, $urandom, $urandom, $urandom};
                    if (pv == '0) pv = 128'd1;
                    @(negedge clk);
                    n = 0;
                    while (!b128.in_ready && n < 400) begin
                        @(negedge clk);
                        n++;
                    end
                    if (!b128.in_ready) begin
                        tests++;
                        fails++;
                        $display("FAIL rand_in_ready_timeout: got 0 expected 1");
                        break;
                    end
                    b128.ab = abv;
                    b128.p = pv;
                    b128.in_valid = 1'b1;
                    q128.push_back(128'(abv % {128'b0, pv}));
                    @(posedge clk);
                end
                #1 b128.in_valid = 1'b0;
            end
            begin
                int cyc = 0;
                while (got < NR && cyc < NR * 300) begin
                    @(negedge clk);
                    cyc++;
                    if (b128.out_valid) begin
                        if (q128.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL rand_unexpected_output: got %0h expected none", b128.r);
                        end else begin
                            chk("rand r", b128.r, q128.pop_front());
                            chk("rand err", 128'(b128.err), 128'(0));
                        end
                        got++;
                    end
                end
            end
        join
        chk("rand outputs", 128'(got), 128'(NR));
        chk("rand queue empty", 128'(q128.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
